// File: rtl/score_keeper_pkg.sv
// Shared game-state encoding, datapath widths and a saturating adder for score_keeper.
package score_keeper_pkg;

  localparam int unsigned SCORE_BITS = 13;
  localparam int unsigned STATE_BITS = 1;
  localparam int unsigned SCORE_W    = SCORE_BITS + 1;
  localparam int unsigned MULT_W     = 3;

  typedef enum logic [STATE_BITS:0] {
    STATE_IDLE  = 2'd0,
    STATE_PLAY  = 2'd1,
    STATE_PAUSE = 2'd2,
    STATE_OVER  = 2'd3
  } gameState_t;

  // Add two counter values and clamp at lim; one extra bit catches the carry.
  function automatic logic [SCORE_W-1:0] satAdd(input logic [SCORE_W-1:0] a,
                                                input logic [SCORE_W-1:0] b,
                                                input logic [SCORE_W-1:0] lim);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum >= {1'b0, lim}) ? lim : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/score_keeper_rise_detect.sv
// Registered rising-edge detector with an optional 2-FF synchronizer in front.
module rise_detect #(
  parameter int unsigned WIDTH = 1,
  parameter bit          SYNC  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] sampled;
  logic [WIDTH-1:0] prev;

  if (SYNC) begin : gSync
    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] stable;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        meta   <= '0;
        stable <= '0;
      end else begin
        meta   <= d;
        stable <= meta;
      end
    end
    assign sampled = stable;
  end else begin : gDirect
    assign sampled = d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
      rise <= '0;
    end else begin
      prev <= sampled;
      rise <= sampled & ~prev;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Score, combo, best-combo and multiplier tracking driven by hit judgements and the metronome beat.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int unsigned SCORE_MAX  = 9999,
  parameter int unsigned COMBO_STEP = 10,
  parameter int unsigned MULT_MAX   = 4,
  parameter int unsigned COMBO_SHOW = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                metronome_clk,
  input  logic [STATE_BITS:0] state,
  input  logic                arrow_valid,
  input  logic                correctHit,
  input  logic                incorrectHit,
  output logic [SCORE_W-1:0]  score,
  output logic [SCORE_W-1:0]  combo_count,
  output logic [SCORE_W-1:0]  best_combo,
  output logic [MULT_W-1:0]   multiplier,
  output logic                combo_active,
  output logic                miss_pulse
);

  localparam logic [SCORE_W-1:0] MAX_V = SCORE_W'(SCORE_MAX);

  gameState_t         gameState;
  logic               beatTick;
  logic               correctRise;
  logic               incorrectRise;
  logic               judged;
  logic               beatArrow;
  logic [SCORE_W-1:0] scoreNext;
  logic [SCORE_W-1:0] comboNext;
  logic               judgedNext;
  logic               missNext;

  assign gameState = gameState_t'(state);

  // Multiplier from combo via a compare chain against constant step thresholds.
  function automatic logic [MULT_W-1:0] multFor(input logic [SCORE_W-1:0] c);
    logic [MULT_W-1:0] m;
    m = MULT_W'(1);
    for (int unsigned i = 1; i < MULT_MAX; i++) begin
      if (32'(c) >= i * COMBO_STEP) m = MULT_W'(i + 1);
    end
    return m;
  endfunction

  rise_detect #(.WIDTH(1), .SYNC(1'b1)) uBeat (
    .clk(clk), .reset_n(reset_n), .d(metronome_clk), .rise(beatTick)
  );
  rise_detect #(.WIDTH(1), .SYNC(1'b0)) uCorrect (
    .clk(clk), .reset_n(reset_n), .d(correctHit), .rise(correctRise)
  );
  rise_detect #(.WIDTH(1), .SYNC(1'b0)) uIncorrect (
    .clk(clk), .reset_n(reset_n), .d(incorrectHit), .rise(incorrectRise)
  );

  // Event first, then miss check against the post-event judged flag, then beat clears judged.
  always_comb begin
    scoreNext  = score;
    comboNext  = combo_count;
    judgedNext = judged;
    missNext   = 1'b0;
    if (gameState == STATE_PLAY) begin
      if (!judged && (correctRise || incorrectRise)) begin
        judgedNext = 1'b1;
        if (incorrectRise) begin
          comboNext = '0;
        end else begin
          comboNext = satAdd(combo_count, SCORE_W'(1), MAX_V);
          scoreNext = satAdd(score, SCORE_W'(multFor(comboNext)), MAX_V);
        end
      end
      if (beatTick) begin
        if (beatArrow && !judgedNext) begin
          comboNext = '0;
          missNext  = 1'b1;
        end
        judgedNext = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score        <= '0;
      combo_count  <= '0;
      best_combo   <= '0;
      multiplier   <= MULT_W'(1);
      combo_active <= 1'b0;
      miss_pulse   <= 1'b0;
      judged       <= 1'b0;
      beatArrow    <= 1'b0;
    end else if (gameState == STATE_IDLE) begin
      score        <= '0;
      combo_count  <= '0;
      best_combo   <= '0;
      multiplier   <= MULT_W'(1);
      combo_active <= 1'b0;
      miss_pulse   <= 1'b0;
      judged       <= 1'b0;
      beatArrow    <= 1'b0;
    end else begin
      score        <= scoreNext;
      combo_count  <= comboNext;
      multiplier   <= multFor(comboNext);
      combo_active <= 32'(comboNext) >= COMBO_SHOW;
      miss_pulse   <= missNext;
      judged       <= judgedNext;
      if (beatTick) beatArrow <= arrow_valid;
      // Trails combo_count by one clock.
      if (combo_count > best_combo) best_combo <= combo_count;
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: beat/hit sequencing, priority, misses, pause, idle, saturation, reset.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        metronome_clk;
  logic [1:0]  state;
  logic        arrow_valid;
  logic        correctHit;
  logic        incorrectHit;

  logic [13:0] score, combo_count, best_combo;
  logic [2:0]  multiplier;
  logic        combo_active, miss_pulse;

  logic [13:0] score20, combo20, best20;
  logic [2:0]  mult20;
  logic        active20, miss20;

  int total = 0;
  int bad = 0;
  int missCount = 0;
  int missBase = 0;

  always #5 clk = ~clk;

  score_keeper dut (
    .clk(clk), .reset_n(reset_n), .metronome_clk(metronome_clk), .state(state),
    .arrow_valid(arrow_valid), .correctHit(correctHit), .incorrectHit(incorrectHit),
    .score(score), .combo_count(combo_count), .best_combo(best_combo),
    .multiplier(multiplier), .combo_active(combo_active), .miss_pulse(miss_pulse)
  );

  score_keeper #(.SCORE_MAX(20)) dut20 (
    .clk(clk), .reset_n(reset_n), .metronome_clk(metronome_clk), .state(state),
    .arrow_valid(arrow_valid), .correctHit(correctHit), .incorrectHit(incorrectHit),
    .score(score20), .combo_count(combo20), .best_combo(best20),
    .multiplier(mult20), .combo_active(active20), .miss_pulse(miss20)
  );

  always @(negedge clk) if (miss_pulse === 1'b1) missCount++;

  task automatic check(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic beat();
    metronome_clk = 1'b1;
    tick(2);
    metronome_clk = 1'b0;
    tick(4);
  endtask

  task automatic hit(input logic c, input logic i);
    correctHit   = c;
    incorrectHit = i;
    tick(1);
    correctHit   = 1'b0;
    incorrectHit = 1'b0;
    tick(3);
  endtask

  initial begin
    reset_n = 1'b0; metronome_clk = 1'b0; state = 2'd0;
    arrow_valid = 1'b0; correctHit = 1'b0; incorrectHit = 1'b0;
    tick(2);
    check("rst_score", int'(score), 0);
    check("rst_combo", int'(combo_count), 0);
    check("rst_best", int'(best_combo), 0);
    check("rst_mult", int'(multiplier), 1);
    check("rst_active", int'(combo_active), 0);
    check("rst_miss", int'(miss_pulse), 0);
    check("rst_best20", int'(best20), 0);
    check("rst_active20", int'(active20), 0);
    check("rst_miss20", int'(miss20), 0);
    reset_n = 1'b1;
    tick(2);

    // 12 correct hits, one per beat
    state = 2'd1; arrow_valid = 1'b1;
    missBase = missCount;
    for (int n = 0; n < 12; n++) begin
      hit(1'b1, 1'b0);
      beat();
    end
    check("t1_combo", int'(combo_count), 12);
    check("t1_mult", int'(multiplier), 2);
    check("t1_score", int'(score), 15);
    check("t1_best", int'(best_combo), 12);
    check("t1_active", int'(combo_active), 1);
    check("t1_nomiss", missCount - missBase, 0);

    // correctHit held across three beats counts once
    state = 2'd0; tick(2);
    check("idle_score", int'(score), 0);
    state = 2'd1; arrow_valid = 1'b0;
    correctHit = 1'b1; tick(1);
    beat(); beat(); beat();
    correctHit = 1'b0; tick(3);
    check("t2_score", int'(score), 1);
    check("t2_combo", int'(combo_count), 1);

    // Two hits in one beat, then simultaneous correct+incorrect
    state = 2'd0; tick(2);
    state = 2'd1;
    hit(1'b1, 1'b0);
    hit(1'b1, 1'b0);
    check("t3_double_score", int'(score), 1);
    check("t3_double_combo", int'(combo_count), 1);
    beat();
    hit(1'b1, 1'b1);
    check("t3_both_combo", int'(combo_count), 0);
    check("t3_both_score", int'(score), 1);
    beat();

    // Build combo 5 then miss a beat with an arrow present
    state = 2'd0; tick(2);
    state = 2'd1; arrow_valid = 1'b1;
    missBase = missCount;
    for (int n = 0; n < 5; n++) begin
      hit(1'b1, 1'b0);
      beat();
    end
    check("t4_combo5", int'(combo_count), 5);
    check("t4_score5", int'(score), 5);
    check("t4_premiss", missCount - missBase, 0);
    beat();
    check("t4_combo0", int'(combo_count), 0);
    check("t4_best", int'(best_combo), 5);
    check("t4_misses", missCount - missBase, 1);
    check("t4_mult", int'(multiplier), 1);

    // Pause freezes, held level is not counted on resume, idle clears
    state = 2'd2;
    for (int n = 0; n < 3; n++) hit(1'b1, 1'b0);
    check("t5_pause_score", int'(score), 5);
    check("t5_pause_combo", int'(combo_count), 0);
    correctHit = 1'b1; tick(3);
    state = 2'd1; tick(4);
    check("t5_resume_score", int'(score), 5);
    check("t5_resume_combo", int'(combo_count), 0);
    correctHit = 1'b0; tick(2);
    state = 2'd0; tick(3);
    check("t5_idle_score", int'(score), 0);
    check("t5_idle_combo", int'(combo_count), 0);
    check("t5_idle_best", int'(best_combo), 0);
    check("t5_idle_mult", int'(multiplier), 1);

    // 25 hits: saturation on the SCORE_MAX=20 instance, full count on the default one
    state = 2'd1; arrow_valid = 1'b0;
    for (int n = 0; n < 25; n++) begin
      hit(1'b1, 1'b0);
      beat();
    end
    check("t6_score", int'(score), 47);
    check("t6_combo", int'(combo_count), 25);
    check("t6_mult", int'(multiplier), 3);
    check("t6_best", int'(best_combo), 25);
    check("t6_sat_score", int'(score20), 20);
    check("t6_sat_combo", int'(combo20), 20);
    check("t6_sat_best", int'(best20), 20);
    check("t6_sat_mult", int'(mult20), 3);

    // Asynchronous reset in the middle of a beat
    metronome_clk = 1'b1; tick(1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_score", int'(score), 0);
    check("t6_rst_combo", int'(combo_count), 0);
    check("t6_rst_best", int'(best_combo), 0);
    check("t6_rst_mult", int'(multiplier), 1);
    check("t6_rst_active", int'(combo_active), 0);
    check("t6_rst_score20", int'(score20), 0);
    check("t6_rst_mult20", int'(mult20), 1);
    metronome_clk = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
